// File: rtl/nor_sweep_ctrl_pkg.sv
// Shared constants for the NOR gate self-test sequencer: FSM encodings and default sizing.
// Latency: none (constants only).
// Backpressure: none (constants only).
package nor_sweep_ctrl_pkg;

    // Sweep FSM encodings, kept as plain 2-bit constants so older tooling can share them
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SETTLE = 2'd1;
    localparam logic [1:0] S_SAMPLE = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    // Default gate width and number of cycles a vector is held before sampling
    localparam int N_IN_DEF          = 3;
    localparam int SETTLE_CYCLES_DEF = 2;

endpackage

// File: rtl/nor_sweep_ctrl_if.sv
// Bundle between the self-test sequencer, the gate under test and the host that starts it.
// Latency: none (wires only).
// Backpressure: none; start is a level request sampled only when the sequencer is idle.
interface nor_sweep_ctrl_if #(
    parameter int N_IN = 3
);
    logic              start;
    logic [N_IN-1:0]   dut_vec;
    logic              dut_out_3in;
    logic              dut_out_inst;
    logic              busy;
    logic              done;
    logic              pass;
    logic [N_IN:0]     err_count;
    logic              first_err_vld;
    logic [N_IN-1:0]   first_err_vec;

    // Host / gate side: requests a sweep, returns gate outputs, observes results
    modport master (
        output start,
        input  dut_vec,
        output dut_out_3in,
        output dut_out_inst,
        input  busy,
        input  done,
        input  pass,
        input  err_count,
        input  first_err_vld,
        input  first_err_vec
    );

    // Sequencer side
    modport slave (
        input  start,
        output dut_vec,
        input  dut_out_3in,
        input  dut_out_inst,
        output busy,
        output done,
        output pass,
        output err_count,
        output first_err_vld,
        output first_err_vec
    );
endinterface

// File: rtl/nor_compare.sv
// Gate block under test: 3-input NOR built two ways (single primitive and from 2-input cells).
// Latency: combinational.
// Backpressure: none.
module nor_compare (
    input  wire a,
    input  wire b,
    input  wire c,
    output wire out_3in,
    output wire out_inst
);
    wire ab_n;
    wire ab;

    nor g_nor3 (out_3in, a, b, c);

    // NOR3 = NOR2(OR2(a,b), c), with the OR2 made as NOR2 followed by an inverter
    nor g_ab  (ab_n, a, b);
    not g_inv (ab, ab_n);
    nor g_abc (out_inst, ab, c);
endmodule

// File: rtl/nor_sweep_vec_cnt.sv
// Vector index and settle-window counter for the gate sweep, with clear/advance controls.
// Latency: counts update on the clock edge after the control input is asserted.
// Backpressure: none; clear wins over advance, advance wins over settle increment.
module nor_sweep_vec_cnt #(
    parameter int N_IN          = 3,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clr,
    input  logic            adv,
    input  logic            settle_en,
    output logic [N_IN-1:0] vec,
    output logic            settle_last,
    output logic            vec_last
);
    localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    logic [N_IN-1:0] vec_q, vec_d;
    logic [CW-1:0]   settle_cnt_q, settle_cnt_d;

    // Next-state for the vector index and the settle counter
    always_comb begin
        vec_d        = vec_q;
        settle_cnt_d = settle_cnt_q;
        if (clr) begin
            vec_d        = '0;
            settle_cnt_d = '0;
        end else if (adv) begin
            vec_d        = vec_q + 1'b1;
            settle_cnt_d = '0;
        end else if (settle_en) begin
            settle_cnt_d = settle_cnt_q + 1'b1;
        end
    end

    // Counter registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            vec_q        <= '0;
            settle_cnt_q <= '0;
        end else begin
            vec_q        <= vec_d;
            settle_cnt_q <= settle_cnt_d;
        end
    end

    assign vec         = vec_q;
    assign settle_last = (settle_cnt_q == CW'(SETTLE_CYCLES - 1));
    assign vec_last    = &vec_q;
endmodule

// File: rtl/nor_sweep_ctrl.sv
// Self-test sequencer: sweeps every input vector into the NOR block, checks both outputs, reports.
// Latency: (2**N_IN)*(SETTLE_CYCLES+1) cycles from the start accept edge to the done pulse.
// Backpressure: start is honoured only in IDLE; requests while busy or in DONE are dropped.
module nor_sweep_ctrl
    import nor_sweep_ctrl_pkg::*;
#(
    parameter int N_IN          = N_IN_DEF,
    parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEF
) (
    input  logic             clk,
    input  logic             rst,
    nor_sweep_ctrl_if.slave  bus
);
    logic [1:0]      state_q, state_d;
    logic [N_IN:0]   err_count_q, err_count_d;
    logic            first_err_vld_q, first_err_vld_d;
    logic [N_IN-1:0] first_err_vec_q, first_err_vec_d;
    logic            pass_q, pass_d;

    logic            cnt_clr;
    logic            cnt_adv;
    logic            cnt_settle_en;
    logic [N_IN-1:0] vec;
    logic            settle_last;
    logic            vec_last;
    logic            golden;
    logic            mismatch;

    nor_sweep_vec_cnt #(
        .N_IN          (N_IN),
        .SETTLE_CYCLES (SETTLE_CYCLES)
    ) u_vec_cnt (
        .clk         (clk),
        .rst         (rst),
        .clr         (cnt_clr),
        .adv         (cnt_adv),
        .settle_en   (cnt_settle_en),
        .vec         (vec),
        .settle_last (settle_last),
        .vec_last    (vec_last)
    );

    // Golden compare; written so an unknown gate output falls through to a mismatch
    always_comb begin
        golden   = ~|vec;
        mismatch = 1'b1;
        if ((bus.dut_out_3in == golden) && (bus.dut_out_inst == golden)) begin
            mismatch = 1'b0;
        end
    end

    // Sweep FSM and result bookkeeping
    always_comb begin
        state_d         = state_q;
        err_count_d     = err_count_q;
        first_err_vld_d = first_err_vld_q;
        first_err_vec_d = first_err_vec_q;
        pass_d          = pass_q;
        cnt_clr         = 1'b0;
        cnt_adv         = 1'b0;
        cnt_settle_en   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d         = S_SETTLE;
                    cnt_clr         = 1'b1;
                    err_count_d     = '0;
                    first_err_vld_d = 1'b0;
                    first_err_vec_d = '0;
                    pass_d          = 1'b0;
                end
            end
            S_SETTLE: begin
                cnt_settle_en = 1'b1;
                if (settle_last) begin
                    state_d = S_SAMPLE;
                end
            end
            S_SAMPLE: begin
                // A vector counts once even when both gate forms are wrong
                if (mismatch) begin
                    if (err_count_q != {(N_IN+1){1'b1}}) begin
                        err_count_d = err_count_q + 1'b1;
                    end
                    if (!first_err_vld_q) begin
                        first_err_vld_d = 1'b1;
                        first_err_vec_d = vec;
                    end
                end
                if (vec_last) begin
                    state_d = S_DONE;
                    pass_d  = (err_count_d == '0);
                end else begin
                    state_d = S_SETTLE;
                    cnt_adv = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and result registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= S_IDLE;
            err_count_q     <= '0;
            first_err_vld_q <= 1'b0;
            first_err_vec_q <= '0;
            pass_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            err_count_q     <= err_count_d;
            first_err_vld_q <= first_err_vld_d;
            first_err_vec_q <= first_err_vec_d;
            pass_q          <= pass_d;
        end
    end

    assign bus.dut_vec       = vec;
    assign bus.busy          = (state_q == S_SETTLE) || (state_q == S_SAMPLE);
    assign bus.done          = (state_q == S_DONE);
    assign bus.pass          = pass_q;
    assign bus.err_count     = err_count_q;
    assign bus.first_err_vld = first_err_vld_q;
    assign bus.first_err_vec = first_err_vec_q;
endmodule

// File: tb/tb_nor_sweep_ctrl.sv
// Bench for the NOR self-test sequencer with the gate block and injectable output faults.
// Latency: checks every cycle of each sweep against the expected schedule.
// Backpressure: exercises dropped start requests, held start and mid-sweep reset.
module tb_nor_sweep_ctrl;
    localparam int NI    = 3;
    localparam int SC    = 2;
    localparam int NV    = 1 << NI;
    localparam int PER   = SC + 1;
    localparam int SWEEP = NV * PER;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    nor_sweep_ctrl_if #(.N_IN(NI)) bus ();

    nor_sweep_ctrl #(.N_IN(NI), .SETTLE_CYCLES(SC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    wire g3;
    wire gi;
    nor_compare gate (
        .a        (bus.dut_vec[2]),
        .b        (bus.dut_vec[1]),
        .c        (bus.dut_vec[0]),
        .out_3in  (g3),
        .out_inst (gi)
    );

    // Fault injection: stuck-at override, or inversion on selected vectors
    logic          st3_en = 1'b0, st3_val = 1'b0, sti_en = 1'b0, sti_val = 1'b0;
    logic [NV-1:0] inv3 = '0, invi = '0;
    assign bus.dut_out_3in  = st3_en ? st3_val : (g3 ^ inv3[bus.dut_vec]);
    assign bus.dut_out_inst = sti_en ? sti_val : (gi ^ invi[bus.dut_vec]);

    int            checks = 0;
    int            errors = 0;
    logic [NV-1:0] exp_bad;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: a vector is bad if either presented output differs from NOR of its bits
    task automatic set_faults(input logic s3e, input logic s3v, input logic sie, input logic siv,
                              input logic [NV-1:0] i3, input logic [NV-1:0] ii);
        logic gold, o3, oi;
        st3_en = s3e; st3_val = s3v; sti_en = sie; sti_val = siv; inv3 = i3; invi = ii;
        for (int v = 0; v < NV; v++) begin
            gold = (v == 0);
            o3   = s3e ? s3v : (gold ^ i3[v]);
            oi   = sie ? siv : (gold ^ ii[v]);
            exp_bad[v] = (o3 != gold) || (oi != gold);
        end
    endtask

    function automatic int bad_before(input int n);
        int c = 0;
        for (int v = 0; v < n; v++) c += exp_bad[v] ? 1 : 0;
        return c;
    endfunction

    function automatic int first_bad();
        for (int v = 0; v < NV; v++) if (exp_bad[v]) return v;
        return 0;
    endfunction

    task automatic chk_all_zero(input string tag);
        chk({tag, " busy"}, 32'(bus.busy), 0);
        chk({tag, " done"}, 32'(bus.done), 0);
        chk({tag, " pass"}, 32'(bus.pass), 0);
        chk({tag, " dut_vec"}, 32'(bus.dut_vec), 0);
        chk({tag, " err_count"}, 32'(bus.err_count), 0);
        chk({tag, " first_err_vld"}, 32'(bus.first_err_vld), 0);
        chk({tag, " first_err_vec"}, 32'(bus.first_err_vec), 0);
    endtask

    // One sweep. pre: accept edge is the next posedge with start already high.
    // keep: leave start high and return in the IDLE cycle after DONE.
    // inj_k / rst_k: cycle after which a one-cycle start pulse / reset is applied (-1 = none).
    task automatic run_sweep(input string tag, input bit pre, input bit keep,
                             input int inj_k, input int rst_k);
        int total;
        total = bad_before(NV);
        if (!pre) begin
            @(negedge clk);
            bus.start = 1'b1;
        end
        @(posedge clk);
        #1;
        if (!keep) bus.start = 1'b0;
        for (int k = 0; k <= SWEEP + 2; k++) begin
            if (k > 0) begin
                @(posedge clk);
                #1;
            end
            if (inj_k >= 0 && k == inj_k + 1) bus.start = 1'b0;
            if (rst_k >= 0 && k == rst_k + 1) begin
                chk_all_zero({tag, " abort"});
                rst = 1'b0;
                @(posedge clk);
                #1;
                chk({tag, " abort no done"}, 32'(bus.done), 0);
                chk({tag, " abort idle"}, 32'(bus.busy), 0);
                return;
            end
            if (k < SWEEP) begin
                chk({tag, " busy"}, 32'(bus.busy), 1);
                chk({tag, " early done"}, 32'(bus.done), 0);
                chk({tag, " dut_vec"}, 32'(bus.dut_vec), 32'(k / PER));
                if (k % PER == 0)
                    chk({tag, " running err_count"}, 32'(bus.err_count), 32'(bad_before(k / PER)));
                if (k == 0) begin
                    chk({tag, " pass cleared"}, 32'(bus.pass), 0);
                    chk({tag, " first_err_vld cleared"}, 32'(bus.first_err_vld), 0);
                end
            end else if (k == SWEEP) begin
                chk({tag, " done"}, 32'(bus.done), 1);
                chk({tag, " busy at done"}, 32'(bus.busy), 0);
                chk({tag, " dut_vec at done"}, 32'(bus.dut_vec), NV - 1);
                chk({tag, " err_count"}, 32'(bus.err_count), 32'(total));
                chk({tag, " pass"}, 32'(bus.pass), 32'(total == 0));
                chk({tag, " first_err_vld"}, 32'(bus.first_err_vld), 32'(total != 0));
                if (total != 0)
                    chk({tag, " first_err_vec"}, 32'(bus.first_err_vec), 32'(first_bad()));
            end else begin
                chk({tag, " done one cycle"}, 32'(bus.done), 0);
                chk({tag, " idle after done"}, 32'(bus.busy), 0);
                chk({tag, " pass held"}, 32'(bus.pass), 32'(total == 0));
                chk({tag, " dut_vec held"}, 32'(bus.dut_vec), NV - 1);
                if (keep) return;
            end
            if (k == inj_k) bus.start = 1'b1;
            if (k == rst_k) rst = 1'b1;
        end
    endtask

    initial begin
        bus.start = 1'b0;
        set_faults(0, 0, 0, 0, '0, '0);
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("reset");
        rst = 1'b0;

        // Good gate
        run_sweep("good", 0, 0, -1, -1);
        // out_inst stuck-at-0: only vec 0 wrong
        set_faults(0, 0, 1, 0, '0, '0);
        run_sweep("inst_sa0", 0, 0, -1, -1);
        // out_3in stuck-at-1: vecs 1..7 wrong
        set_faults(1, 1, 0, 0, '0, '0);
        run_sweep("3in_sa1", 0, 0, -1, -1);
        // Both outputs wrong on vec 5 only: counted once
        set_faults(0, 0, 0, 0, 8'h20, 8'h20);
        run_sweep("both_v5", 0, 0, -1, -1);
        // Start pulse during SETTLE of vec 3 is dropped
        set_faults(0, 0, 0, 0, '0, '0);
        run_sweep("start_ignored", 0, 0, 3 * PER, -1);
        // Reset during vec 4 of a failing sweep aborts, then a fresh sweep starts at vec 0
        set_faults(0, 0, 0, 0, 8'h01, '0);
        run_sweep("abort", 0, 0, -1, 4 * PER);
        set_faults(0, 0, 0, 0, '0, '0);
        run_sweep("after_abort", 0, 0, -1, -1);
        // Held start: back-to-back sweeps, results clear at each accept
        run_sweep("held_a", 0, 1, -1, -1);
        set_faults(0, 0, 0, 0, 8'h44, 8'h81);
        run_sweep("held_b", 1, 1, -1, -1);
        set_faults(0, 0, 0, 0, '0, '0);
        run_sweep("held_c", 1, 0, -1, -1);
        // Randomized fault patterns
        for (int r = 0; r < 6; r++) begin
            set_faults(($urandom_range(0, 3) == 0), 1'($urandom), ($urandom_range(0, 3) == 0),
                       1'($urandom), ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom),
                       ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom));
            run_sweep("random", 0, 0, -1, -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
